// File: rtl/servo_ref_pkg.sv
// Shared types and constants for the servo reference path.
package servo_ref_pkg;

  localparam int unsigned REF_W        = 9;
  localparam int unsigned POT_W        = 8;
  localparam int unsigned REF_MIN_C    = 20;
  localparam int unsigned REF_MAX_C    = 340;
  localparam int unsigned REF_CENTER_C = 180;
  localparam int unsigned PRESC_W      = 16;
  localparam int unsigned SETTLE_W     = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    SETTLE = 2'd2
  } state_e;

  // Clamp a reference code into [lo, hi].
  function automatic logic [REF_W-1:0] clamp_ref(input logic [REF_W-1:0] v,
                                                 input logic [REF_W-1:0] lo,
                                                 input logic [REF_W-1:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Divide-by-STEP_DIV tick generator: tick is high for the last count of each period.
module step_prescaler #(
  parameter int unsigned STEP_DIV = 1000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  // Count 0..STEP_DIV-1 while enabled; clear has priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ref_ramp_sequencer.sv
// Servo reference sequencer: slews ref_out toward a commanded target one code
// per STEP_DIV clocks, settles, then pulses done.
// Optional build macro REF_SATURATE_EN: clamp out-of-range commands instead
// of discarding them with an err pulse.
module ref_ramp_sequencer
  import servo_ref_pkg::*;
#(
  parameter int unsigned REF_MIN    = REF_MIN_C,
  parameter int unsigned REF_MAX    = REF_MAX_C,
  parameter int unsigned REF_INIT   = REF_CENTER_C,
  parameter int unsigned STEP_DIV   = 1000,
  parameter int unsigned SETTLE_CYC = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [REF_W-1:0] cmd_ref,
  output logic             cmd_ready,
  input  logic             abort,
  output logic [REF_W-1:0] ref_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [REF_W-1:0]    MIN_V       = REF_W'(REF_MIN);
  localparam logic [REF_W-1:0]    MAX_V       = REF_W'(REF_MAX);
  localparam logic [REF_W-1:0]    INIT_V      = REF_W'(REF_INIT);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);

  state_e              state_q, state_d;
  logic [REF_W-1:0]    ref_q, ref_d;
  logic [REF_W-1:0]    tgt_q, tgt_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                done_d, err_d;

  logic                cmd_acc;
  logic [REF_W-1:0]    cmd_tgt;
  logic                cmd_legal;
  logic [REF_W-1:0]    step_v;
  logic                presc_clr, presc_en, step_tick;

  assign cmd_ready = (state_q == IDLE) && !abort;
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign ref_out   = ref_q;

`ifdef REF_SATURATE_EN
  assign cmd_tgt   = clamp_ref(cmd_ref, MIN_V, MAX_V);
  assign cmd_legal = 1'b1;
`else
  assign cmd_tgt   = cmd_ref;
  assign cmd_legal = (cmd_ref >= MIN_V) && (cmd_ref <= MAX_V);
`endif

  // One code toward the target; target is always in range so this never overshoots.
  assign step_v = (ref_q < tgt_q) ? ref_q + REF_W'(1) : ref_q - REF_W'(1);

  // Prescaler runs only in RAMP; it is held at zero otherwise and on abort.
  assign presc_en  = (state_q == RAMP);
  assign presc_clr = (state_q != RAMP) || abort;

  step_prescaler #(
    .STEP_DIV (STEP_DIV),
    .CNT_W    (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (presc_clr),
    .en    (presc_en),
    .tick  (step_tick)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    tgt_d    = tgt_q;
    settle_d = settle_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_acc) begin
          tgt_d = cmd_tgt;
          if (!cmd_legal) begin
            err_d = 1'b1;
          end else if (cmd_tgt == ref_q) begin
            done_d = 1'b1;
          end else begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (step_tick) begin
          ref_d = step_v;
          if (step_v == tgt_q) begin
            state_d  = SETTLE;
            settle_d = '0;
          end
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d  = IDLE;
          settle_d = '0;
        end else if (settle_q == SETTLE_LAST) begin
          state_d  = IDLE;
          settle_d = '0;
          done_d   = 1'b1;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        settle_d = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ref_q    <= INIT_V;
      tgt_q    <= INIT_V;
      settle_q <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      tgt_q    <= tgt_d;
      settle_q <= settle_d;
      done     <= done_d;
      err      <= err_d;
      busy     <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_ref_ramp_sequencer.sv
// Scoreboard bench for ref_ramp_sequencer (STEP_DIV=4, SETTLE_CYC=8).
module tb_ref_ramp_sequencer;
  import servo_ref_pkg::*;

  localparam int STEP  = 4;
  localparam int SETL  = 8;
  localparam int EV_DONE = 0;
  localparam int EV_ERR  = 1;

  typedef struct {
    int kind;
    int cyc;
    int refv;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       abort = 1'b0;
  logic [8:0] cmd_ref = 9'd0;
  logic       cmd_ready, busy, done, err;
  logic [8:0] ref_out;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   m_ref = 180;
  ev_t  sbq[$];

  ref_ramp_sequencer #(
    .STEP_DIV   (STEP),
    .SETTLE_CYC (SETL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ref   (cmd_ref),
    .cmd_ready (cmd_ready),
    .abort     (abort),
    .ref_out   (ref_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference position: start value r0 moves toward t by one code per STEP
  // clocks after acceptance edge acc; value as seen in cycle c.
  function automatic int traj(input int r0, input int t, input int acc, input int c);
    int n, k;
    n = (t > r0) ? t - r0 : r0 - t;
    k = (c > acc) ? (c - acc) / STEP : 0;
    if (k > n) k = n;
    return (t >= r0) ? r0 + k : r0 - k;
  endfunction

  // Monitor: every done/err pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && (done || err)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", int'({done, err}), 0);
      end else begin
        ev_t e;
        e = sbq.pop_front();
        chk("event_kind", err ? EV_ERR : EV_DONE, e.kind);
        chk("event_cycle", cyc, e.cyc);
        chk("event_ref", int'(ref_out), e.refv);
      end
    end
  end

  task automatic drain(input int bound);
    for (int i = 0; i < bound && sbq.size() != 0; i++) @(negedge clk);
    chk("events_pending", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    abort = 1'b0;
    #1;
    chk("rst_ref", int'(ref_out), 180);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    sbq.delete();
    m_ref = 180;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Issue one command; abort_at: -1 none, -2 random chance, >=0 cycles after acceptance.
  task automatic run_cmd(input int v, input int abort_at);
    int   t, acc, n, done_c, ab, frozen;
    bit   legal;
    ev_t  e;
    @(posedge clk); #1;
    chk("ready_idle", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_ref   = 9'(v);
    @(posedge clk); #1;
    acc = cyc;
    cmd_valid = 1'b0;
`ifdef REF_SATURATE_EN
    t = (v < 20) ? 20 : (v > 340) ? 340 : v;
    legal = 1'b1;
`else
    t = v;
    legal = (v >= 20) && (v <= 340);
`endif
    if (!legal) begin
      e = '{EV_ERR, acc, m_ref};
      sbq.push_back(e);
      drain(4);
      chk("err_ref_hold", int'(ref_out), m_ref);
      return;
    end
    if (t == m_ref) begin
      e = '{EV_DONE, acc, m_ref};
      sbq.push_back(e);
      drain(4);
      return;
    end
    n = (t > m_ref) ? t - m_ref : m_ref - t;
    done_c = acc + n * STEP + SETL;
    e = '{EV_DONE, done_c, t};
    sbq.push_back(e);
    ab = abort_at;
    if (ab == -2) ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, done_c - acc - 1)) : -1;
    do begin
      @(negedge clk);
      chk("ref_traj", int'(ref_out), traj(m_ref, t, acc, cyc));
      chk("busy_active", int'(busy), 1);
      chk("ready_busy", int'(cmd_ready), 0);
      if (ab >= 0 && cyc == acc + ab) begin
        frozen = traj(m_ref, t, acc, cyc);
        abort = 1'b1;
        void'(sbq.pop_back());
        @(posedge clk); #1;
        abort = 1'b0;
        m_ref = frozen;
        repeat (3) begin
          @(negedge clk);
          chk("abort_busy", int'(busy), 0);
          chk("abort_ref", int'(ref_out), frozen);
        end
        return;
      end
    end while (cyc < done_c - 1);
    drain(4);
    @(negedge clk);
    chk("end_busy", int'(busy), 0);
    chk("end_ref", int'(ref_out), t);
    m_ref = t;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v, r;
    do_reset();
    @(negedge clk);
    chk("idle_ref", int'(ref_out), 180);
    chk("idle_ready", int'(cmd_ready), 1);
    chk("idle_busy", int'(busy), 0);

    run_cmd(185, -1);
    run_cmd(177, -1);
    do_reset();
    run_cmd(190, 9);
    chk("abort_freeze_182", m_ref, 182);
    run_cmd(182, -1);
    run_cmd(400, -1);

    // cmd_valid masked by abort in IDLE
    @(posedge clk); #1;
    abort = 1'b1;
    cmd_valid = 1'b1;
    cmd_ref = 9'(m_ref == 200 ? 210 : 200);
    #1 chk("ready_masked", int'(cmd_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("masked_busy", int'(busy), 0);
    chk("masked_ref", int'(ref_out), m_ref);
    abort = 1'b0;
    cmd_valid = 1'b0;

    for (int i = 0; i < 25; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) v = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 19)) : int'($urandom_range(341, 511));
      else if (r == 1) v = m_ref;
      else begin
        v = m_ref + int'($urandom_range(0, 30)) - 15;
        if (v < 20) v = 20;
        if (v > 340) v = 340;
      end
      run_cmd(v, -2);
    end

    // asynchronous reset in the middle of a ramp
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_ref = 9'(m_ref < 300 ? m_ref + 10 : m_ref - 10);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre_reset_busy", int'(busy), 1);
    do_reset();
    @(negedge clk);
    chk("post_reset_ref", int'(ref_out), 180);
    run_cmd(181, -1);

    repeat (4) @(negedge clk);
    chk("final_queue", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
